// File: rtl/ex_pkg.sv
// Shared execute-stage definitions for the iterative RV64M multiply/divide unit.
package ex_pkg;

   localparam int XLEN = 64;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mdState_t;

   localparam int MULDIV_LATENCY = XLEN + 2;

endpackage

// File: rtl/ex_muldiv_seq.sv
// Radix-2 multiply/divide sequencer: magnitudes are iterated with one shared
// adder/subtractor, signs are restored in FIX, and the RISC-V divide special
// cases bypass the loop entirely.
module ex_muldiv_seq #(
   parameter int XLEN  = ex_pkg::XLEN,
   parameter int CNT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);
   import ex_pkg::*;

   mdState_t              state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2:0]            op_q, op_d;
   logic                  negRes_q, negRes_d;
   logic                  negRem_q, negRem_d;
   logic [XLEN-1:0]       acc_q, acc_d;
   logic [XLEN-1:0]       lo_q, lo_d;
   logic [XLEN-1:0]       mag_q, mag_d;
   logic [XLEN-1:0]       result_q, result_d;

   logic                  isDivIn, aSigned, bSigned, aNeg, bNeg;
   logic [XLEN-1:0]       aMag, bMag;
   logic                  divZero, divOvf, fastHit;
   logic [XLEN-1:0]       fastVal;
   logic [XLEN:0]         addA, addB, sum;
   logic                  addSub;
   logic [2*XLEN-1:0]     prodFix;
   logic [XLEN-1:0]       quoFix, remFix, fixVal;

   // Decode the incoming op: signedness, operand magnitudes and the special cases
   always_comb begin
      isDivIn = funct3[2];
      aSigned = funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
      bSigned = funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
      aNeg    = aSigned && op_a[XLEN-1];
      bNeg    = bSigned && op_b[XLEN-1];
      aMag    = aNeg ? -op_a : op_a;
      bMag    = bNeg ? -op_b : op_b;
      divZero = isDivIn && (op_b == '0);
      divOvf  = (funct3 == F3_DIV || funct3 == F3_REM) &&
                (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
      fastHit = divZero || divOvf;
      fastVal = '0;
      if (divZero) begin
         fastVal = funct3[1] ? op_a : '1;
      end else if (divOvf) begin
         fastVal = funct3[1] ? '0 : op_a;
      end
   end

   // Shared adder: add-multiplicand for multiply, trial subtract for divide
   always_comb begin
      if (op_q[2]) begin
         addA   = {acc_q, lo_q[XLEN-1]};
         addB   = {1'b0, mag_q};
         addSub = 1'b1;
      end else begin
         addA   = {1'b0, acc_q};
         addB   = lo_q[0] ? {1'b0, mag_q} : '0;
         addSub = 1'b0;
      end
      sum = addA + (addSub ? ~addB : addB) + {{XLEN{1'b0}}, addSub};
   end

   // Sign fix-up of the finished magnitude result and op-specific selection
   always_comb begin
      prodFix = negRes_q ? -{acc_q, lo_q} : {acc_q, lo_q};
      quoFix  = negRes_q ? -lo_q : lo_q;
      remFix  = negRem_q ? -acc_q : acc_q;
      case (op_q)
         F3_MUL:                   fixVal = prodFix[XLEN-1:0];
         F3_MULH, F3_MULHSU,
         F3_MULHU:                 fixVal = prodFix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:          fixVal = quoFix;
         default:                  fixVal = remFix;
      endcase
   end

   // Sequencing FSM next state, iteration step and result capture
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      negRes_d = negRes_q;
      negRem_d = negRem_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      mag_d    = mag_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               op_d     = funct3;
               negRes_d = aNeg ^ bNeg;
               negRem_d = aNeg;
               if (fastHit) begin
                  state_d  = DONE;
                  result_d = fastVal;
               end else begin
                  state_d = CALC;
                  cnt_d   = CNT_W'(XLEN - 1);
                  acc_d   = '0;
                  lo_d    = isDivIn ? aMag : bMag;
                  mag_d   = isDivIn ? bMag : aMag;
               end
            end
         end
         CALC: begin
            if (op_q[2]) begin
               if (!sum[XLEN]) begin
                  acc_d = sum[XLEN-1:0];
                  lo_d  = {lo_q[XLEN-2:0], 1'b1};
               end else begin
                  acc_d = addA[XLEN-1:0];
                  lo_d  = {lo_q[XLEN-2:0], 1'b0};
               end
            end else begin
               acc_d = sum[XLEN:1];
               lo_d  = {sum[0], lo_q[XLEN-1:1]};
            end
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIX: begin
            state_d  = DONE;
            result_d = fixVal;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   // State, datapath and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         negRes_q <= 1'b0;
         negRem_q <= 1'b0;
         acc_q    <= '0;
         lo_q     <= '0;
         mag_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         negRes_q <= negRes_d;
         negRem_q <= negRem_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         mag_q    <= mag_d;
         result_q <= result_d;
      end
   end

   assign stall        = (state_q == IDLE && start && !flush) ||
                         state_q == CALC || state_q == FIX;
   assign busy         = (state_q != IDLE);
   assign result_valid = (state_q == DONE) && !flush;
   assign result       = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for the iterative multiply/divide sequencer.
module tb_ex_muldiv_seq;

   localparam int XLEN = 64;

   logic            clk;
   logic            rst;
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] opA;
   logic [XLEN-1:0] opB;
   logic            flush;
   logic            stall;
   logic            busy;
   logic            resultValid;
   logic [XLEN-1:0] result;

   int total;
   int bad;

   ex_muldiv_seq #(.XLEN(XLEN)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .funct3       (funct3),
      .op_a         (opA),
      .op_b         (opB),
      .flush        (flush),
      .stall        (stall),
      .busy         (busy),
      .result_valid (resultValid),
      .result       (result)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one op for a single cycle (or hold start) and report stall in the start cycle
   task automatic applyStimulus(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] b, input logic hold,
                                output logic st0);
      @(posedge clk); #1;
      funct3 = f3;
      opA    = a;
      opB    = b;
      start  = 1'b1;
      @(negedge clk);
      st0 = stall;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
   endtask

   // Count cycles after the accepting edge until result_valid, bounded
   task automatic waitValid(output int lat, output int stallCyc, output logic stallDone,
                            output logic [XLEN-1:0] res);
      bit found;
      found     = 1'b0;
      lat       = -1;
      stallCyc  = 0;
      stallDone = 1'b0;
      res       = '0;
      for (int c = 1; c <= 200 && !found; c++) begin
         @(negedge clk);
         if (resultValid) begin
            found     = 1'b1;
            lat       = c;
            stallDone = stall;
            res       = result;
         end else begin
            if (stall) stallCyc++;
            @(posedge clk); #1;
         end
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL timeout: result_valid=0 after 200 cycles, required a pulse");
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; opA = '0; opB = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (resultValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", resultValid); end
      total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
      rst = 1'b0;
   endtask

   task automatic test_mul_latency();
      logic st0, stD; int lat, sc; logic [XLEN-1:0] res;
      applyStimulus(3'b000, 64'd7, -64'sd3, 1'b0, st0);
      waitValid(lat, sc, stD, res);
      total++; if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mul_result got=%h exp=ffffffffffffffeb", res); end
      total++; if (lat != 66) begin bad++; $display("FAIL mul_latency got=%0d exp=66", lat); end
      total++; if (st0 !== 1'b1) begin bad++; $display("FAIL mul_stall_start got=%b exp=1", st0); end
      total++; if (sc != 65) begin bad++; $display("FAIL mul_stall_cycles got=%0d exp=65", sc); end
      total++; if (stD !== 1'b0) begin bad++; $display("FAIL mul_stall_done got=%b exp=0", stD); end
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (resultValid !== 1'b0) begin bad++; $display("FAIL mul_pulse got=%b exp=0", resultValid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mul_busy_after got=%b exp=0", busy); end
      total++; if (result !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mul_hold got=%h exp=ffffffffffffffeb", result); end
   endtask

   task automatic test_mulh();
      logic [2:0]      f3[3];
      logic [XLEN-1:0] va[3], vb[3], ve[3];
      logic st0, stD; int lat, sc; logic [XLEN-1:0] res;
      f3 = '{3'b011, 3'b001, 3'b010};
      va = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      vb = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      ve = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(f3[i], va[i], vb[i], 1'b0, st0);
         waitValid(lat, sc, stD, res);
         total++; if (res !== ve[i]) begin bad++; $display("FAIL mulh_result[%0d] got=%h exp=%h", i, res, ve[i]); end
         total++; if (lat != 66) begin bad++; $display("FAIL mulh_latency[%0d] got=%0d exp=66", i, lat); end
      end
   endtask

   task automatic test_div();
      logic [2:0]      f3[6];
      logic [XLEN-1:0] va[6], vb[6], ve[6];
      logic st0, stD; int lat, sc; logic [XLEN-1:0] res;
      f3 = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b111};
      va = '{-64'sd7, -64'sd7, 64'd7, 64'd7, 64'd100, 64'd100};
      vb = '{64'd2, 64'd2, -64'sd2, -64'sd2, 64'd7, 64'd7};
      ve = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 64'd14, 64'd2};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(f3[i], va[i], vb[i], 1'b0, st0);
         waitValid(lat, sc, stD, res);
         total++; if (res !== ve[i]) begin bad++; $display("FAIL div_result[%0d] got=%h exp=%h", i, res, ve[i]); end
         total++; if (lat != 66) begin bad++; $display("FAIL div_latency[%0d] got=%0d exp=66", i, lat); end
      end
   endtask

   task automatic test_flush();
      logic st0, stD; int lat, sc; logic [XLEN-1:0] res;
      applyStimulus(3'b000, 64'd9, 64'd9, 1'b0, st0);
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(negedge clk);
      total++; if (resultValid !== 1'b0) begin bad++; $display("FAIL flush_valid_calc got=%b exp=0", resultValid); end
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
      total++; if (resultValid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", resultValid); end
      total++; if (result !== 64'd2) begin bad++; $display("FAIL flush_result_hold got=%h exp=2", result); end
      // flush alongside start in IDLE must not accept
      @(posedge clk); #1;
      funct3 = 3'b000; opA = 64'd3; opB = 64'd4; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_start_stall got=%b exp=0", stall); end
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_start_busy got=%b exp=0", busy); end
      applyStimulus(3'b000, 64'd3, 64'd4, 1'b0, st0);
      waitValid(lat, sc, stD, res);
      total++; if (res !== 64'd12) begin bad++; $display("FAIL flush_mul_result got=%h exp=c", res); end
      total++; if (lat != 66) begin bad++; $display("FAIL flush_mul_latency got=%0d exp=66", lat); end
   endtask

   task automatic test_fast_path();
      logic [2:0]      f3[4];
      logic [XLEN-1:0] va[4], vb[4], ve[4];
      logic st0, stD; int lat, sc; logic [XLEN-1:0] res;
      f3 = '{3'b101, 3'b110, 3'b100, 3'b110};
      va = '{64'd5, 64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
      vb = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      ve = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h8000_0000_0000_0000, 64'd0};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(f3[i], va[i], vb[i], 1'b0, st0);
         waitValid(lat, sc, stD, res);
         total++; if (res !== ve[i]) begin bad++; $display("FAIL fast_result[%0d] got=%h exp=%h", i, res, ve[i]); end
         total++; if (lat != 1) begin bad++; $display("FAIL fast_latency[%0d] got=%0d exp=1", i, lat); end
         total++; if (st0 !== 1'b1) begin bad++; $display("FAIL fast_stall_start[%0d] got=%b exp=1", i, st0); end
         total++; if (sc != 0 || stD !== 1'b0) begin bad++; $display("FAIL fast_stall_after[%0d] got=%0d/%b exp=0/0", i, sc, stD); end
      end
   endtask

   task automatic test_reset_mid();
      logic st0;
      applyStimulus(3'b000, 64'd5, 64'd5, 1'b0, st0);
      for (int i = 0; i < 64; i++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++; if (busy !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL fix_busy_stall got=%b/%b exp=1/1", busy, stall); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      total++; if (resultValid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", resultValid); end
      total++; if (result !== '0) begin bad++; $display("FAIL rstmid_result got=%h exp=0", result); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b exp=0", stall); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if (resultValid !== 1'b0) begin bad++; $display("FAIL rstmid_late_valid[%0d] got=%b exp=0", i, resultValid); end
      end
   endtask

   task automatic test_held_start();
      logic st0, stD; int lat, sc; logic [XLEN-1:0] res;
      applyStimulus(3'b101, 64'd100, 64'd7, 1'b1, st0);
      waitValid(lat, sc, stD, res);
      total++; if (res !== 64'd14) begin bad++; $display("FAIL held_result got=%h exp=e", res); end
      total++; if (lat != 66) begin bad++; $display("FAIL held_latency got=%0d exp=66", lat); end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_busy got=%b exp=0", busy); end
      total++; if (resultValid !== 1'b0) begin bad++; $display("FAIL held_valid got=%b exp=0", resultValid); end
      total++; if (result !== 64'd14) begin bad++; $display("FAIL held_hold got=%h exp=e", result); end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_busy2 got=%b exp=0", busy); end
   endtask

   // Scenario sequence; test_flush relies on test_div leaving REMU 100/7 = 2 in result
   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_mul_latency();
      test_mulh();
      test_div();
      test_flush();
      test_fast_path();
      test_reset_mid();
      test_held_start();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
- Iterative multi-cycle multiply/divide sequencer for the RV64M instructions, sitting in the execute stage beside the single-cycle ALU.
- Accepts an M-extension op from ID/EX and runs a radix-2 shift-add or shift-subtract loop.
- Holds the pipeline via a stall output until the 64-bit result is ready.
- Owns the sequencing FSM, iteration counter, sign fix-up and RISC-V special cases (divide-by-zero, signed overflow).

Parameters:
- XLEN, 64, operand/result width; the iteration count equals XLEN.
- CNT_W, $clog2(XLEN), iteration counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  ID/EX holds a valid M-extension op (opcode OP, funct7=0000001).
- funct3  input  3  M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value after forwarding.
- op_b  input  XLEN  rs2 value after forwarding.
- flush  input  1  branch/exception flush of the EX instruction.
- stall  output  1  hold IF/ID/EX; combinational.
- busy  output  1  FSM not in IDLE; registered.
- result_valid  output  1  one-cycle pulse; result is valid.
- result  output  XLEN  final value; held until the next accepted start.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset: state=IDLE, counter=0, busy=0, result_valid=0, result=0, all internal accumulators 0. rst mid-operation aborts immediately; no result_valid is produced.
- Accept: start=1 in IDLE at edge E0. Latch funct3, latch operand magnitudes, latch sign flags (signed ops only; MULHSU treats op_b as unsigned).
- Normal path: IDLE->CALC at E0; CALC runs XLEN iterations, counter XLEN-1 down to 0; CALC->FIX at E64; FIX->DONE at E65. result_valid=1 in the cycle after E65. DONE->IDLE unconditionally at the next edge.
- Multiply: 128-bit product of magnitudes. Negate when the signs differ. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring division on magnitudes.
  - Quotient is negated when the signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
- Fast path, IDLE->DONE directly at E0 (result_valid the cycle after E0):
  - divisor=0: DIV/DIVU result all ones; REM/REMU result op_a.
  - DIV/REM with op_a=0x8000_0000_0000_0000 and op_b=all ones: DIV result op_a; REM result 0.
- stall = (state==IDLE && start && !flush) || state==CALC || state==FIX. stall is 0 in DONE, so the pipeline advances at the edge ending DONE.
- start while busy, including in DONE, is ignored; it is the same instruction still occupying EX.
- flush=1: any state->IDLE at the next edge; no result_valid. flush with start in IDLE does not accept. flush wins over DONE, and result_valid is suppressed that cycle.
- result updates only on entering DONE.

Decomposition:
- Shared package ex_pkg:
  - XLEN.
  - M-op funct3 localparams (F3_MUL … F3_REMU).
  - FSM state enum (2-bit encoding IDLE=0, CALC=1, FIX=2, DONE=3).
  - MULDIV_LATENCY=XLEN+2.
- Single module with no sub-module; the shared add/sub datapath stays inline.

Test Plan:
- MUL op_a=7, op_b=-3 -> result=0xFFFF_FFFF_FFFF_FFEB. result_valid pulses exactly 66 cycles after start. stall=1 for cycles 0..65.
- MULHU op_a=op_b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE. MULH on the same operands -> 0.
- DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Fast paths:
  - DIVU 5/0 -> all ones.
  - REM 5/0 -> 5.
  - DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000.
  - Each gives result_valid 1 cycle after start, with stall high for the start cycle only.
- Flush:
  - flush at CALC iteration 30 -> IDLE next edge, no result_valid.
  - Immediate new MUL 3*4 -> 12 at normal latency.
- Reset and ignored start:
  - rst during FIX -> all outputs 0 next cycle.
  - start held high through DONE does not re-launch; busy=0 the cycle after DONE.
